// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter sharing one UART transmitter
// Optional owner-stall timeout is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]   i_req_last,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic                 o_busy,
    output logic                 o_tx_latch,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_empty,
    output logic                 o_timeout_err
);
    localparam int IW = $clog2(NUM_REQ);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    logic [2:0]         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [IW-1:0]      r_owner;
    logic [IW-1:0]      r_last_owner;
    logic               r_last_q;
    logic [7:0]         r_tx_data;

    logic               w_own_valid;
    logic               w_own_last;
    logic [7:0]         w_own_data;
    logic               w_found;
    logic [IW-1:0]      w_pick;
    logic [IW-1:0]      w_cand;
    logic               w_accept;
    logic               w_timeout;

    always_comb begin
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        w_own_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == IW'(i)) begin
                w_own_valid = i_req_valid[i];
                w_own_last  = i_req_last[i];
                w_own_data  = i_req_data[i*8 +: 8];
            end
        end
    end

    // Search starts just after the previous owner so it never gets back-to-back priority.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last_owner;
        w_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IW'((int'(r_last_owner) + k) % NUM_REQ);
            if (!w_found && i_req_valid[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    assign w_accept    = (r_state == ST_LOAD) && w_own_valid && i_tx_empty;
    assign o_req_ready = w_accept ? r_grant : '0;
    assign o_grant     = r_grant;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_tx_latch  = (r_state == ST_LATCH);
    assign o_tx_data   = r_tx_data;

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_to_cnt;
    logic        r_timeout_err;

    // Only an owner with nothing to offer is timed out; waiting on the UART is not.
    assign w_timeout     = (r_state == ST_LOAD) && !w_own_valid && (r_to_cnt == TO_LAST);
    assign o_timeout_err = r_timeout_err;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_to_cnt      <= 16'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if ((r_state == ST_LOAD) && !w_own_valid && !w_timeout) begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end else if ((r_state != ST_LOAD) || w_accept || w_timeout) begin
                r_to_cnt <= 16'd0;
            end
        end
    end
`else
    logic [15:0] w_unused_to;
    assign w_unused_to   = 16'(TIMEOUT_CYCLES);
    assign w_timeout     = 1'b0;
    assign o_timeout_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= IW'(NUM_REQ - 1);
            r_last_q     <= 1'b0;
            r_tx_data    <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
                        r_owner <= w_pick;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_tx_data <= w_own_data;
                        r_last_q  <= w_own_last;
                        r_state   <= ST_LATCH;
                    end else if (w_timeout) begin
                        r_last_owner <= r_owner;
                        r_grant      <= '0;
                        r_state      <= ST_IDLE;
                    end
                end
                ST_LATCH: r_state <= ST_HOLD;
                // Dead cycle: the UART's tx_empty may not have dropped yet.
                ST_HOLD:  r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (i_tx_empty) begin
                        if (r_last_q) begin
                            r_last_owner <= r_owner;
                            r_grant      <= '0;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- Shares the single `uart` transmitter in `m3_ice_top` between `NUM_REQ` byte-stream requesters, such as the command-response generator, the bus monitor and the GPIO/event reporter.
- Arbitration is round-robin at packet granularity. Once a requester is granted, it owns the UART until it presents a byte with `req_last` set, so packets never interleave on the host link.
- The block drives the UART's `tx_latch`/`tx_data` pair and paces every byte on `tx_empty`.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters (2–8).
- `TIMEOUT_CYCLES`, default 65535: stall limit in clk cycles. Used only with `UART_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `req_valid` in NUM_REQ: requester i has a byte available.
- `req_data` in 8*NUM_REQ: byte of requester i at bits [8i+7:8i].
- `req_last` in NUM_REQ: the byte on requester i ends its packet.
- `req_ready` out NUM_REQ: one-hot, one-cycle pulse. The byte of requester i is consumed this cycle.
- `grant` out NUM_REQ: one-hot current owner; all zeros when idle.
- `busy` out 1: high whenever state ≠ IDLE.
- `tx_latch` out 1: one-cycle load strobe to `uart`.
- `tx_data` out 8: registered byte to `uart`. Stable from the LATCH cycle until the next LOAD.
- `tx_empty` in 1: `uart` transmitter idle.
- `timeout_err` out 1: one-cycle pulse when an owner is forcibly released. Tied 0 without the macro.

## Operation

State machine: IDLE, LOAD, LATCH, HOLD, WAIT.

- **IDLE**
  - If any `req_valid` bit is set, pick the first set bit searching upward from (`last_owner`+1) mod NUM_REQ, with wrap-around.
  - Register `grant` to that requester and go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD**
  - If `req_valid[owner]` and `tx_empty` are both high:
    - capture `req_data[owner]` into `tx_data`;
    - capture `req_last[owner]` into `last_q`;
    - pulse `req_ready[owner]`;
    - go to LATCH.
  - Otherwise stay in LOAD. Other requesters are ignored.
- **LATCH**: `tx_latch` = 1 for exactly this cycle; go to HOLD.
- **HOLD**: one dead cycle with `tx_empty` ignored, to cover the UART's deassert latency; go to WAIT.
- **WAIT**
  - When `tx_empty` = 1:
    - if `last_q` is set: `last_owner` ← owner, clear `grant`, go to IDLE;
    - otherwise go to LOAD.

General rules:
- Valid bits from non-owners never change `grant` mid-packet.
- The current owner gets no priority in the next arbitration. Round-robin starts after `last_owner`.
- A single-byte packet is a byte with `req_last` = 1 in its first LOAD.
- Requesters must hold `req_data`/`req_last` stable while `req_valid` is high and `req_ready` is low.
- The arbiter never asserts `tx_latch` unless `tx_empty` was 1 in the preceding LOAD cycle.

## Timing

- Reset values (state IDLE):
  - `grant`, `req_ready`, `tx_latch`, `busy`, `timeout_err` = 0;
  - `tx_data` = 8'h00;
  - `last_q` = 0;
  - `last_owner` = NUM_REQ-1, so requester 0 wins first;
  - timeout counter = 0.
- Latency from `req_valid` rising in IDLE:
  - `grant` and `busy` high one cycle later (LOAD);
  - `req_ready` in that LOAD cycle if `tx_empty` = 1;
  - `tx_latch` the following cycle.
- Byte-to-byte overhead: LOAD + LATCH + HOLD + one WAIT cycle minimum, on top of the UART frame time. With 8N1 at `baud_div` 174, the frame time is 10×174 cycles.
- The UART must drop `tx_empty` within one cycle of `tx_latch`.
- Simultaneous request and release: if an owner finishes in WAIT and a new `req_valid` appears in the same cycle, the new request is serviced from IDLE on the next cycle. There is always one IDLE cycle between packets.
- Reset mid-packet:
  - returns to IDLE and drops `tx_latch`/`grant` immediately;
  - a byte already being shifted by the UART is not aborted;
  - the next LOAD waits for `tx_empty`, so nothing is clobbered.

## Configuration

`UART_ARB_TIMEOUT_EN`:

- **Defined**
  - A 16-bit counter increments each cycle in LOAD while `req_valid[owner]` = 0, and clears on any accepted byte or on leaving LOAD.
  - When the counter reaches `TIMEOUT_CYCLES`:
    - pulse `timeout_err` for one cycle;
    - set `last_owner` ← owner;
    - clear `grant`;
    - go to IDLE.
  - Stalls while waiting on `tx_empty` are never timed out.
- **Undefined**: no counter. An owner that stalls holds the UART indefinitely, and `timeout_err` is constant 0.

## Test plan

1. **Single requester.** Requester 0 sends 3 bytes 8'hA5, 8'h5A, 8'hFF with last on the third.
   - Required: three `tx_latch` pulses carrying those values in order.
   - Required: each `tx_latch` follows `tx_empty` high.
   - Required: `grant` returns to 0 one cycle after the final WAIT exit.
2. **No interleave.** Requesters 1 and 2 are valid simultaneously from reset, each with a 2-byte packet.
   - Required: requester 1 is served first and both its bytes go out before any byte of requester 2.
   - Required: `last_owner` = 2 afterwards.
3. **Round-robin fairness.** All 4 requesters continuously send 1-byte packets.
   - Required: grant order 0,1,2,3,0,1… for 12 packets.
   - Required: no requester is served twice in a row.
4. **Reset mid-packet.** Assert `reset` low for 2 cycles during WAIT of byte 2 of a 4-byte packet.
   - Required: all outputs go to their reset values.
   - Required: after the UART's `tx_empty` rises, requester 0 is granted first.
   - Required: no `tx_latch` while `tx_empty` = 0.
5. **Timeout, macro defined** (`TIMEOUT_CYCLES`=100). The owner drops `req_valid` after its first non-last byte.
   - Required: exactly one `timeout_err` pulse, 100 cycles after LOAD entry.
   - Required: the next requester is granted from IDLE.
   - Without the macro, `grant` holds indefinitely and `timeout_err` stays 0.
6. **Back-pressure.** Hold `tx_empty` = 0 during LOAD for 50 cycles.
   - Required: no `req_ready` pulse and no `tx_latch` until `tx_empty` rises.
   - Required: `req_ready` pulses in the LOAD cycle where `tx_empty` is high, and `tx_latch` follows one cycle later.
